// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align: load/store unit with misaligned-access splitting and load extend.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  input  logic            we_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            flush_i,
  output logic            lsu_stall_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            rdata_valid_o,
  output logic            err_o,
  output logic            dmem_req_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic            dmem_we_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  input  logic            dmem_err_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_LO  = 3'd1,
    S_WAIT_LO = 3'd2,
    S_REQ_HI  = 3'd3,
    S_WAIT_HI = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_split;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-9:0]   r_hi;
  logic              r_err;
  logic              r_flushed;

  logic [1:0]        w_in_size;
  logic              w_in_split;
  logic [3:0]        w_mask;
  logic [7:0]        w_be;
  logic [2*XLEN-1:0] w_wdata;
  logic [XLEN-1:0]   w_shifted;
  logic [XLEN-1:0]   w_ext;
  logic [XLEN-1:0]   w_base;

  // Size 3 is folded into word at capture so downstream logic sees only 0..2.
  assign w_in_size  = (size_i == 2'd3) ? 2'd2 : size_i;
  assign w_in_split = ((w_in_size == 2'd2) && (addr_i[1:0] != 2'd0)) ||
                      ((w_in_size == 2'd1) && (addr_i[1:0] == 2'd3));

  always_comb begin
    case (r_size)
      2'd0:    w_mask = 4'b0001;
      2'd1:    w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  // Low half of each 8-bit/64-bit view belongs to the lo word, high half to hi.
  assign w_be    = {4'b0000, w_mask} << r_addr[1:0];
  assign w_wdata = {{XLEN{1'b0}}, r_wdata} << {r_addr[1:0], 3'b000};
  assign w_base  = {r_addr[XLEN-1:2], 2'b00};

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_shifted = r_lo;
      2'd1:    w_shifted = {r_hi[7:0],  r_lo[31:8]};
      2'd2:    w_shifted = {r_hi[15:0], r_lo[31:16]};
      default: w_shifted = {r_hi[23:0], r_lo[31:24]};
    endcase
  end

  always_comb begin
    case (r_size)
      2'd0:    w_ext = {{24{~r_uns & w_shifted[7]}},  w_shifted[7:0]};
      2'd1:    w_ext = {{16{~r_uns & w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_size    <= 2'd0;
      r_uns     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_split   <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_err     <= 1'b0;
      r_flushed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (ex_valid_i) begin
            r_we      <= we_i;
            r_size    <= w_in_size;
            r_uns     <= unsigned_i;
            r_addr    <= addr_i;
            r_wdata   <= wdata_i;
            r_split   <= w_in_split;
            r_lo      <= '0;
            r_hi      <= '0;
            r_err     <= 1'b0;
            r_flushed <= 1'b0;
          end
        end
        S_WAIT_LO: begin
          if (dmem_rvalid_i) begin
            r_lo <= dmem_rdata_i;
            if (dmem_err_i) r_err <= 1'b1;
          end
        end
        S_WAIT_HI: begin
          if (dmem_rvalid_i) begin
            r_hi <= dmem_rdata_i[XLEN-9:0];
            if (dmem_err_i) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
      // Once a request is granted the op runs to completion; flush only mutes RESP.
      if (flush_i && ((r_state == S_WAIT_LO) || (r_state == S_REQ_HI) ||
                      (r_state == S_WAIT_HI))) begin
        r_flushed <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    lsu_stall_o   = 1'b0;
    rdata_o       = '0;
    rdata_valid_o = 1'b0;
    err_o         = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_addr_o   = '0;
    dmem_we_o     = 1'b0;
    dmem_be_o     = 4'b0000;
    dmem_wdata_o  = '0;
    case (r_state)
      S_IDLE: begin
        lsu_stall_o = ex_valid_i & ~rst_i;
        if (ex_valid_i) w_state_nxt = S_REQ_LO;
      end
      S_REQ_LO: begin
        lsu_stall_o = 1'b1;
        if (flush_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          dmem_req_o   = 1'b1;
          dmem_addr_o  = w_base;
          dmem_we_o    = r_we;
          dmem_be_o    = w_be[3:0];
          dmem_wdata_o = w_wdata[XLEN-1:0];
          if (dmem_gnt_i) w_state_nxt = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        lsu_stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          if (dmem_err_i || !r_split) w_state_nxt = S_RESP;
          else                        w_state_nxt = S_REQ_HI;
        end
      end
      S_REQ_HI: begin
        lsu_stall_o  = 1'b1;
        dmem_req_o   = 1'b1;
        dmem_addr_o  = w_base + 32'd4;
        dmem_we_o    = r_we;
        dmem_be_o    = w_be[7:4];
        dmem_wdata_o = w_wdata[2*XLEN-1:XLEN];
        if (dmem_gnt_i) w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        lsu_stall_o = 1'b1;
        if (dmem_rvalid_i) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (!r_flushed) begin
          err_o = r_err;
          if (!r_we) begin
            rdata_valid_o = 1'b1;
            rdata_o       = r_err ? '0 : w_ext;
          end
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire
